spi_reg_slave: RTL and testbench
================================

# spi_reg_slave

System-clocked SPI mode-0 slave that turns SPI frames from `spi_master` into register reads and writes on an internal register bus. Unlike the free-running `spi_slave`, it oversamples `sclk`, `cs_n` and `mosi` in the `clk` domain and decodes a command/address/data frame format. It sits between the external SPI pins and a register file, which answers with fixed 1-cycle read latency.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `sclk`, `cs_n` and `mosi` (legal values ≥2).
- `clk` input 1: system clock; must satisfy f_clk ≥ 8 × f_sclk.
- `rst` input 1: reset, synchronous and active-high.
- `sclk`, `cs_n`, `mosi` input 1 each: asynchronous SPI pins.
- `miso` output 1: serial data out, MSB first.
- `miso_oe` output 1: high while the synchronized `cs_n` is low.
- `reg_addr` output 7: register address.
- `reg_wdata` output 8: write data.
- `reg_we` output 1: 1-cycle write strobe.
- `reg_re` output 1: 1-cycle read strobe.
- `reg_rdata` input 8: read data, valid exactly 1 `clk` after `reg_re`.
- `frame_active` output 1: a frame is in progress.
- `frame_done` output 1: 1-cycle pulse on `cs_n` deassertion.

## Operation
- Frame format:
  - Byte 0 is the command `{rw, addr[6:0]}`; `rw`=1 means read.
  - Bytes 1..N are data. The address auto-increments after each data byte and wraps 127→0.
- States:
  - IDLE → CMD on `cs_n` falling edge, with the bit counter cleared.
  - CMD → WR_DATA or RD_DATA after the 8th `sclk` rising edge, chosen by `rw`.
  - Any state → IDLE on `cs_n` rising edge.
- Bit sampling: `mosi` is sampled on each detected `sclk` rising edge into an 8-bit shift register. The bit counter is 3 bits and wraps 7→0.
- Write (WR_DATA): on each completed byte, drive `reg_wdata`=byte and `reg_addr`=current address with `reg_we`=1 for one cycle, then increment the address. `miso` shifts out 0x00.
- Read:
  - `miso` shifts out 0x00 during CMD.
  - On the CMD completion cycle, load the address and pulse `reg_re`.
  - Capture `reg_rdata` into the tx buffer on the following cycle.
  - At the next `sclk` falling edge, load the buffer into the tx shift register.
  - After each RD_DATA byte completes, increment the address and pulse `reg_re` again (prefetch), so reads stream with no gap.
- `miso` is driven from the tx shift MSB, and the shift register shifts left on each detected `sclk` falling edge. `miso`=0 whenever `miso_oe`=0.
- Partial byte at `cs_n` rise: discarded, with no `reg_we`.
- Simultaneous events: if the `cs_n` rise and the 8th rising edge are detected in the same cycle, the byte is discarded.
- Reset mid-frame: go to IDLE. A sticky `wait_cs_high` flag blocks frame start until synchronized `cs_n` has been seen high.
- Edges of `sclk` while `cs_n` is high are ignored.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `frame_active`=0, `frame_done`=0, state=IDLE, `wait_cs_high`=0.
- Pin-to-edge-detect latency: SYNC_STAGES+1 `clk` cycles.
- Strobe timing: `reg_we` and `reg_re` assert the cycle after the 8th rising edge is detected. `reg_rdata` is captured at `reg_re`+1.
- The first read bit appears on `miso` the cycle after the `sclk` falling edge that follows the command byte's 8th rising edge is detected. At f_clk ≥ 8×f_sclk this meets the master's next rising-edge sample.
- Edge-following signals:
  - `frame_active` and `miso_oe` follow synchronized `cs_n` with 1-cycle register delay.
  - `frame_done` pulses the same cycle `frame_active` falls.
- All outputs are registered.

## Structure
- Package `spi_pkg`:
  - state enum (`IDLE`, `CMD`, `WR_DATA`, `RD_DATA`);
  - constants `SPI_BYTE_W`=8, `SPI_ADDR_W`=7, `CMD_RW_BIT`=7.
- Sub-module `spi_edge_sync`: an N-stage synchronizer plus a previous-value flop. It outputs `level`, `rise` and `fall`. It is instantiated for `sclk` and `cs_n`; `mosi` uses the `level` output only.

## Test plan
- Write frame: `cs_n` low, command 0x05, data 0xA5 → one `reg_we` with `reg_addr`=0x05 and `reg_wdata`=0xA5; `frame_done` pulses once.
- Burst write: command 0x7F, data 0x11, 0x22 → writes at 0x7F then 0x00 (address wrap).
- Read burst: command 0x83, register file returns 0x3C@3 and 0xC3@4 → master receives 0x3C then 0xC3 with no gap; `miso` is 0 during the command byte.
- Abort: `cs_n` rises after 5 bits of a write data byte → no `reg_we`; state is IDLE; the next frame decodes correctly.
- Reset mid-frame: `rst` asserted during byte 1 while `cs_n` stays low → all outputs return to reset values; `sclk` edges are ignored until `cs_n` goes high and low again.
- Simultaneous event: `cs_n` rise aligned with the 8th `sclk` rise of a write byte → no `reg_we`; `frame_done` pulses.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_pkg : shared widths, command-field layout and frame-decoder states.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_ADDR_W = 7;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_edge_sync : N-stage synchronizer with rise/fall detection.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Left unreset so the chain keeps tracking the pin through reset; a pin
    // already low at reset release then produces no spurious edge.
    always_ff @(posedge clk) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        r_prev <= r_sync[SYNC_STAGES-1];
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = level & ~r_prev;
    assign fall  = ~level & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_reg_slave : oversampled SPI mode-0 slave decoding cmd/addr/data frames |
// | into register-bus reads and writes.                          Rev 1.0       |
// +----------------------------------------------------------------------------+
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [SPI_ADDR_W-1:0] reg_addr,
    output logic [SPI_BYTE_W-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [SPI_BYTE_W-1:0] reg_rdata,
    output logic                  frame_active,
    output logic                  frame_done
);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .i_async(sclk), .level(w_sclk_level), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .i_async(cs_n), .level(w_cs_level), .rise(w_cs_rise), .fall(w_cs_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .i_async(mosi), .level(w_mosi), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );

    spi_state_t            r_state, w_state_next;
    logic [2:0]            r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_rx_shift;
    logic [SPI_BYTE_W-1:0] r_tx_shift;
    logic [SPI_BYTE_W-1:0] r_tx_buf;
    logic                  r_load_pend;
    logic                  r_re_d;
    logic [SPI_ADDR_W-1:0] r_addr;
    logic [SPI_BYTE_W-1:0] r_wdata;
    logic                  r_we;
    logic                  r_re;
    logic                  r_frame_active;
    logic                  r_frame_done;
    logic                  r_wait_cs_high;
    logic                  r_rst_q;

    logic                  w_start;
    logic                  w_bit_rx;
    logic                  w_byte_done;
    logic [SPI_BYTE_W-1:0] w_rx_byte;
    logic                  w_we_set;
    logic                  w_re_set;
    logic                  w_unused;

    assign w_unused = &{1'b0, w_sclk_level, w_mosi_rise, w_mosi_fall, r_rx_shift[SPI_BYTE_W-1]};

    assign w_rx_byte   = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
    // A cs_n rise in the same cycle as an sclk rise wins: the bit is dropped.
    assign w_bit_rx    = (r_state != IDLE) && w_sclk_rise && !w_cs_rise;
    assign w_byte_done = w_bit_rx && (r_bit_cnt == 3'd7);
    assign w_start     = (r_state == IDLE) && w_cs_fall && !r_wait_cs_high;

    always_comb begin
        w_state_next = r_state;
        w_we_set     = 1'b0;
        w_re_set     = 1'b0;
        if (w_cs_rise) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        w_state_next = CMD;
                    end
                end
                CMD: begin
                    if (w_byte_done) begin
                        w_state_next = w_rx_byte[CMD_RW_BIT] ? RD_DATA : WR_DATA;
                        w_re_set     = w_rx_byte[CMD_RW_BIT];
                    end
                end
                WR_DATA: begin
                    w_we_set = w_byte_done;
                end
                RD_DATA: begin
                    w_re_set = w_byte_done;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_bit_cnt      <= 3'd0;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_tx_buf       <= '0;
            r_load_pend    <= 1'b0;
            r_re_d         <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_re           <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_wait_cs_high <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_we           <= w_we_set;
            r_re           <= w_re_set;
            r_re_d         <= r_re;
            r_frame_active <= (w_state_next != IDLE);
            r_frame_done   <= w_cs_rise && (r_state != IDLE);

            // Coming out of reset with cs_n still low: hold off until it returns high.
            if (w_cs_level) begin
                r_wait_cs_high <= 1'b0;
            end else if (r_rst_q) begin
                r_wait_cs_high <= 1'b1;
            end

            if (w_start) begin
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= '0;
            end else if (w_bit_rx) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_rx_shift <= w_rx_byte;
            end

            // Reads advance at byte completion (prefetch); writes advance after the strobe.
            if (w_byte_done && (r_state == CMD)) begin
                r_addr <= w_rx_byte[SPI_ADDR_W-1:0];
            end else if (w_byte_done && (r_state == RD_DATA)) begin
                r_addr <= r_addr + 7'd1;
            end else if (r_we) begin
                r_addr <= r_addr + 7'd1;
            end

            if (w_we_set) begin
                r_wdata <= w_rx_byte;
            end

            if (w_state_next == IDLE) begin
                r_tx_shift  <= '0;
                r_load_pend <= 1'b0;
            end else begin
                if (r_re_d) begin
                    r_tx_buf    <= reg_rdata;
                    r_load_pend <= 1'b1;
                end
                if (w_sclk_fall) begin
                    if (r_load_pend) begin
                        r_tx_shift  <= r_tx_buf;
                        r_load_pend <= 1'b0;
                    end else begin
                        r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign miso         = r_tx_shift[SPI_BYTE_W-1];
    assign miso_oe      = r_frame_active;
    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign reg_we       = r_we;
    assign reg_re       = r_re;
    assign frame_active = r_frame_active;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_reg_slave : directed SPI frames against spi_reg_slave.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_spi_reg_slave;
    import spi_pkg::*;

    localparam int HALF = 8;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_active;
    logic       frame_done;

    spi_reg_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .frame_active(frame_active), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    int         we_cnt = 0;
    int         re_cnt = 0;
    int         done_cnt = 0;
    logic [6:0] we_addr [64];
    logic [7:0] we_data [64];
    logic [6:0] re_addr [64];

    always @(negedge clk) begin
        if (reg_we && we_cnt < 64) begin
            we_addr[we_cnt] = reg_addr;
            we_data[we_cnt] = reg_wdata;
            we_cnt++;
        end
        if (reg_re && re_cnt < 64) begin
            re_addr[re_cnt] = reg_addr;
            re_cnt++;
        end
        if (frame_done) done_cnt++;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_miso"}, 32'(miso), 32'h0);
        check_eq({pfx, "_miso_oe"}, 32'(miso_oe), 32'h0);
        check_eq({pfx, "_reg_addr"}, 32'(reg_addr), 32'h0);
        check_eq({pfx, "_reg_wdata"}, 32'(reg_wdata), 32'h0);
        check_eq({pfx, "_reg_we"}, 32'(reg_we), 32'h0);
        check_eq({pfx, "_reg_re"}, 32'(reg_re), 32'h0);
        check_eq({pfx, "_frame_active"}, 32'(frame_active), 32'h0);
        check_eq({pfx, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        logic [7:0] rx, rx0, rx1, rx2;
        int we0, re0, done0;

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        for (int a = 0; a < 128; a++) mem[a] = 8'(a);
        mem[3] = 8'h3C;
        mem[4] = 8'hC3;
        repeat (6) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single write
        we0 = we_cnt; done0 = done_cnt;
        frame_begin();
        check_eq("wr_frame_active", 32'(frame_active), 32'h1);
        check_eq("wr_miso_oe", 32'(miso_oe), 32'h1);
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'hA5, 8, rx);
        frame_end();
        check_eq("wr_we_count", 32'(we_cnt - we0), 32'd1);
        check_eq("wr_addr", 32'(we_addr[we0]), 32'h05);
        check_eq("wr_data", 32'(we_data[we0]), 32'hA5);
        check_eq("wr_done_count", 32'(done_cnt - done0), 32'd1);
        check_eq("wr_addr_after", 32'(reg_addr), 32'h06);
        check_eq("wr_frame_inactive", 32'(frame_active), 32'h0);

        // Burst write across the address wrap
        we0 = we_cnt;
        frame_begin();
        spi_xfer(8'h7F, 8, rx);
        spi_xfer(8'h11, 8, rx);
        spi_xfer(8'h22, 8, rx);
        frame_end();
        check_eq("burst_we_count", 32'(we_cnt - we0), 32'd2);
        check_eq("burst_addr0", 32'(we_addr[we0]), 32'h7F);
        check_eq("burst_data0", 32'(we_data[we0]), 32'h11);
        check_eq("burst_addr1", 32'(we_addr[we0 + 1]), 32'h00);
        check_eq("burst_data1", 32'(we_data[we0 + 1]), 32'h22);

        // Read burst
        we0 = we_cnt; re0 = re_cnt;
        frame_begin();
        spi_xfer(8'h83, 8, rx0);
        spi_xfer(8'h00, 8, rx1);
        spi_xfer(8'h00, 8, rx2);
        frame_end();
        check_eq("rd_cmd_miso", 32'(rx0), 32'h00);
        check_eq("rd_byte0", 32'(rx1), 32'h3C);
        check_eq("rd_byte1", 32'(rx2), 32'hC3);
        check_eq("rd_re_addr0", 32'(re_addr[re0]), 32'h03);
        check_eq("rd_re_addr1", 32'(re_addr[re0 + 1]), 32'h04);
        check_eq("rd_no_we", 32'(we_cnt - we0), 32'd0);

        // Abort mid data byte, then a clean frame
        we0 = we_cnt; done0 = done_cnt;
        frame_begin();
        spi_xfer(8'h10, 8, rx);
        spi_xfer(8'hFF, 5, rx);
        frame_end();
        check_eq("abort_no_we", 32'(we_cnt - we0), 32'd0);
        check_eq("abort_done", 32'(done_cnt - done0), 32'd1);
        check_eq("abort_state", 32'(dut.r_state), 32'(IDLE));
        frame_begin();
        spi_xfer(8'h21, 8, rx);
        spi_xfer(8'h5A, 8, rx);
        frame_end();
        check_eq("post_abort_we_count", 32'(we_cnt - we0), 32'd1);
        check_eq("post_abort_addr", 32'(we_addr[we0]), 32'h21);
        check_eq("post_abort_data", 32'(we_data[we0]), 32'h5A);

        // Reset in the middle of a frame with cs_n held low
        frame_begin();
        spi_xfer(8'h30, 8, rx);
        spi_xfer(8'h77, 3, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        we0 = we_cnt;
        spi_xfer(8'h31, 8, rx);
        spi_xfer(8'h44, 8, rx);
        repeat (HALF) @(negedge clk);
        check_eq("midrst_ignored_we", 32'(we_cnt - we0), 32'd0);
        check_eq("midrst_ignored_active", 32'(frame_active), 32'h0);
        frame_end();
        frame_begin();
        spi_xfer(8'h32, 8, rx);
        spi_xfer(8'h66, 8, rx);
        frame_end();
        check_eq("midrst_next_we_count", 32'(we_cnt - we0), 32'd1);
        check_eq("midrst_next_addr", 32'(we_addr[we0]), 32'h32);
        check_eq("midrst_next_data", 32'(we_data[we0]), 32'h66);

        // cs_n rise coincident with the 8th sclk rise of a data byte
        we0 = we_cnt; done0 = done_cnt;
        frame_begin();
        spi_xfer(8'h40, 8, rx);
        spi_xfer(8'h99, 7, rx);
        @(negedge clk);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        repeat (3 * HALF) @(negedge clk);
        check_eq("simul_no_we", 32'(we_cnt - we0), 32'd0);
        check_eq("simul_done", 32'(done_cnt - done0), 32'd1);
        check_eq("simul_inactive", 32'(frame_active), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
